// File: rtl/zxvga_scan_ctrl_pkg.sv
// Shared zxvga raster constants, mode-state encoding and horizontal geometry helpers.
// Timing codes: 000/001 = 48k, 010/011 = 128k, 100 = Pentagon; 101..111 are passed through.
package zxvga_scan_ctrl_pkg;

    localparam int unsigned H_W  = 11;
    localparam int unsigned V_W  = 10;
    localparam int unsigned MT_W = 3;

    localparam int unsigned H_TOTAL_DEF  = 864;
    localparam int unsigned H_ACTIVE_DEF = 720;
    localparam int unsigned H_SYNC_DEF   = 64;
    localparam int unsigned V_TOTAL_DEF  = 625;
    localparam int unsigned V_ACTIVE_DEF = 576;
    localparam int unsigned V_FP_DEF     = 5;
    localparam int unsigned V_SYNC_DEF   = 5;

    localparam int unsigned HFP_48K  = 48;
    localparam int unsigned HFP_128K = 64;

    // Only this bit of the timing code selects the porch geometry.
    localparam int unsigned MT_GEOM_BIT = 1;

    typedef enum logic {
        ST_ACTIVE  = 1'b0,
        ST_PENDING = 1'b1
    } mode_state_t;

    // Horizontal sync window, start inclusive, end exclusive.
    typedef struct packed {
        logic [H_W-1:0] hs_start;
        logic [H_W-1:0] hs_end;
    } hgeom_t;

    function automatic logic [H_W-1:0] hfp_of(input logic [MT_W-1:0] mode);
        return mode[MT_GEOM_BIT] ? H_W'(HFP_128K) : H_W'(HFP_48K);
    endfunction

endpackage

// File: rtl/zxvga_hgeom.sv
// Combinational horizontal geometry: timing code -> front porch and hsync window.
module zxvga_hgeom
    import zxvga_scan_ctrl_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF
) (
    input  logic [MT_W-1:0] mode,
    output hgeom_t          geom_c
);

    logic [H_W-1:0] hfp_c;

    // Back porch is whatever remains of the fixed line length after sync.
    always_comb begin
        hfp_c           = hfp_of(mode);
        geom_c.hs_start = H_W'(H_ACTIVE) + hfp_c;
        geom_c.hs_end   = H_W'(H_ACTIVE) + hfp_c + H_W'(H_SYNC);
    end

endmodule

// File: rtl/zxvga_scan_ctrl.sv
// zxvga raster sequencer: h/v counters, registered DE/sync decodes and a
// frame-boundary mode switch so geometry never changes mid-frame.
module zxvga_scan_ctrl
    import zxvga_scan_ctrl_pkg::*;
#(
    parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [MT_W-1:0] machine_timing,
    output logic [H_W-1:0]  hcount,
    output logic [V_W-1:0]  vcount,
    output logic            de,
    output logic            hsync,
    output logic            vsync,
    output logic            frame_start,
    output logic [MT_W-1:0] mode_active,
    output logic            mode_pending
);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    mode_state_t     state, state_nxt;
    logic [MT_W-1:0] mode_nxt;
    logic            run;
    logic            frame_end;
    logic [H_W-1:0]  h_nxt;
    logic [V_W-1:0]  v_nxt;
    logic            de_nxt, hsync_nxt, vsync_nxt, fs_nxt;
    hgeom_t          geom;

    assign frame_end = (hcount == H_LAST) && (vcount == V_LAST);

    // Mode FSM: hold a differing request until the last clock of the frame.
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_active;
        case (state)
            ST_ACTIVE: begin
                if (machine_timing != mode_active) begin
                    state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_end) begin
                    state_nxt = ST_ACTIVE;
                    mode_nxt  = machine_timing;
                end else if (machine_timing == mode_active) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            default: state_nxt = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_ACTIVE;
            mode_active  <= machine_timing;
            mode_pending <= 1'b0;
        end else begin
            state        <= state_nxt;
            mode_active  <= mode_nxt;
            mode_pending <= (state_nxt == ST_PENDING);
        end
    end

    // Counters hold at 0 for the first post-reset clock so it shows h=0,v=0 with DE.
    always_comb begin
        h_nxt = hcount;
        v_nxt = vcount;
        if (!run) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (hcount == H_LAST) begin
            h_nxt = '0;
            v_nxt = (vcount == V_LAST) ? '0 : vcount + V_W'(1);
        end else begin
            h_nxt = hcount + H_W'(1);
        end
    end

    // Geometry follows the mode that will be in force on the next cycle.
    zxvga_hgeom #(
        .H_ACTIVE (H_ACTIVE),
        .H_SYNC   (H_SYNC)
    ) u_hgeom (
        .mode   (mode_nxt),
        .geom_c (geom)
    );

    // Decode the next counter values so registered pins line up with hcount/vcount.
    always_comb begin
        de_nxt    = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hsync_nxt = ((h_nxt >= geom.hs_start) && (h_nxt < geom.hs_end)) ? HS_POL : ~HS_POL;
        vsync_nxt = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? VS_POL : ~VS_POL;
        fs_nxt    = (h_nxt == '0) && (v_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            run         <= 1'b0;
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            run         <= 1'b1;
            de          <= de_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_zxvga_scan_ctrl.sv
// Randomised check of zxvga_scan_ctrl against a frame-position reference model
// (full horizontal geometry, shortened vertical total to keep frames short).
module tb_zxvga_scan_ctrl;

    localparam int unsigned HT    = 864;
    localparam int unsigned HA    = 720;
    localparam int unsigned HSY   = 64;
    localparam int unsigned VT    = 12;
    localparam int unsigned VA    = 6;
    localparam int unsigned VFPL  = 2;
    localparam int unsigned VSY   = 2;
    localparam int unsigned FRAME = HT * VT;
    localparam int unsigned MAX_ERR = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  mt = 3'b000;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        de, hsync, vsync, frame_start, mode_pending;
    logic [2:0]  mode_active;

    always #5 clk = ~clk;

    zxvga_scan_ctrl #(
        .H_TOTAL  (HT),
        .H_ACTIVE (HA),
        .H_SYNC   (HSY),
        .V_TOTAL  (VT),
        .V_ACTIVE (VA),
        .V_FP     (VFPL),
        .V_SYNC   (VSY),
        .HS_POL   (1'b0),
        .VS_POL   (1'b0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .machine_timing (mt),
        .hcount         (hcount),
        .vcount         (vcount),
        .de             (de),
        .hsync          (hsync),
        .vsync          (vsync),
        .frame_start    (frame_start),
        .mode_active    (mode_active),
        .mode_pending   (mode_pending)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position within the frame plus requested/applied mode.
    int unsigned pos = 0;
    bit          in_rst = 1'b0;
    bit          m_valid = 1'b0;
    logic [2:0]  m_mode = 3'b000;
    bit          m_pend = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            in_rst  = 1'b1;
            m_valid = 1'b1;
            pos     = 0;
            m_mode  = mt;
            m_pend  = 1'b0;
        end else if (in_rst) begin
            in_rst = 1'b0;
            m_pend = (mt != m_mode);
        end else begin
            if (m_pend && pos == FRAME - 1) begin
                m_mode = mt;
                m_pend = 1'b0;
            end else begin
                m_pend = (mt != m_mode);
            end
            pos = (pos + 1) % FRAME;
        end
    end

    always @(negedge clk) begin
        int unsigned h, v, hfp;
        logic e_de, e_hs, e_vs, e_fs;
        if (m_valid && n_err < MAX_ERR) begin
            h   = pos % HT;
            v   = pos / HT;
            hfp = m_mode[1] ? 64 : 48;
            if (in_rst) begin
                h = 0; v = 0;
                e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
            end else begin
                e_de = (h < HA) && (v < VA);
                e_hs = !((h >= HA + hfp) && (h < HA + hfp + HSY));
                e_vs = !((v >= VA + VFPL) && (v < VA + VFPL + VSY));
                e_fs = (h == 0) && (v == 0);
            end
            check("hcount",       32'(hcount),       h);
            check("vcount",       32'(vcount),       v);
            check("de",           32'(de),           32'(e_de));
            check("hsync",        32'(hsync),        32'(e_hs));
            check("vsync",        32'(vsync),        32'(e_vs));
            check("frame_start",  32'(frame_start),  32'(e_fs));
            check("mode_active",  32'(mode_active),  32'(m_mode));
            check("mode_pending", 32'(mode_pending), 32'(m_pend));
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset(input int unsigned n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
    endtask

    initial begin
        int unsigned spent;
        int unsigned r;
        step(3);
        reset = 1'b0;
        // 48k geometry across a full frame boundary.
        step(FRAME + 20);
        // 128k held through reset.
        mt = 3'b010;
        pulse_reset(2);
        step(3 * HT);
        // Request then revert within one frame.
        mt = 3'b000;
        step(HT + 17);
        mt = 3'b010;
        step(5);
        // Pentagon request completing at the boundary.
        mt = 3'b100;
        step(FRAME + 50);
        spent = 0;
        while (spent < 36000 && n_err < MAX_ERR) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                mt = 3'($urandom_range(0, 7));
            end else if (r <= 6) begin
                mt = m_mode;
            end else if (r == 7) begin
                if ($urandom_range(0, 1) == 1) mt = 3'($urandom_range(0, 7));
                pulse_reset($urandom_range(1, 3));
            end
            r = $urandom_range(1, 3000);
            step(r);
            spent += r;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
